// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_TRAP
  } state_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Architectural PC register with sequential-address adder and alignment check
// on the value about to be loaded.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic [31:0] q_4,
  output logic        d_misaligned
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

  assign q_4          = q + 32'd4;
  assign d_misaligned = |d[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, holds the fetched word
// until the consumer accepts it, handles flush-redirect and misaligned trap.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          next_pc,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          flush_addr,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_valid,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  output logic [31:0]          pc,
  output logic [31:0]          pc_4,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] inst_count
);

  state_t      state;
  logic        drop;
  logic        pc_load;
  logic [31:0] pc_d;
  logic        target_misaligned;

  // Flush outranks accept; nothing loads the PC once trapped.
  always_comb begin
    pc_d    = flush ? flush_addr : next_pc;
    pc_load = (state != S_TRAP) && (flush || ((state == S_HOLD) && !stall));
  end

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (pc_load),
    .d           (pc_d),
    .q           (pc),
    .q_4         (pc_4),
    .d_misaligned(target_misaligned)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      inst       <= NOP;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      misaligned <= 1'b0;
      inst_count <= '0;
      drop       <= 1'b0;
    end else if (state != S_TRAP) begin
      if (flush) begin
        inst_valid <= 1'b0;
        // A response still in flight must be discarded; one arriving now already is.
        drop       <= (state == S_FETCH) && !imem_valid;
        if (target_misaligned) begin
          state      <= S_TRAP;
          imem_req   <= 1'b0;
          misaligned <= 1'b1;
        end else begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
          S_FETCH: begin
            if (imem_valid) begin
              if (drop) begin
                drop <= 1'b0;
              end else begin
                inst       <= imem_rdata;
                inst_valid <= 1'b1;
                imem_req   <= 1'b0;
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              inst_count <= inst_count + CNT_WIDTH'(1);
              inst_valid <= 1'b0;
              if (target_misaligned) begin
                state      <= S_TRAP;
                misaligned <= 1'b1;
              end else begin
                state    <= S_FETCH;
                imem_req <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level memory plus a behavioural
// model of the fetch rules, compared every cycle on the falling edge.
module tb_fetch_unit;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst, stall, flush, imem_valid;
  logic [31:0]   next_pc, flush_addr, imem_rdata;
  logic          imem_req, inst_valid, misaligned;
  logic [31:0]   imem_addr, inst, pc, pc_4;
  logic [CW-1:0] inst_count;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .next_pc   (next_pc),
    .stall     (stall),
    .flush     (flush),
    .flush_addr(flush_addr),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .inst      (inst),
    .inst_valid(inst_valid),
    .pc        (pc),
    .pc_4      (pc_4),
    .misaligned(misaligned),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          t = 0;
  bit          seq = 1'b1;

  // Memory: a single pending request, tagged stale if redirected away from.
  bit          pend = 1'b0, pstale = 1'b0, vstale = 1'b0;
  int          due = 0;
  logic [31:0] paddr = '0;
  int unsigned lat_lo = 1, lat_hi = 1;

  // Reference model of the architectural view.
  logic [31:0]   m_pc = '0, m_inst = 32'h0000_0013;
  logic [CW-1:0] m_cnt = '0;
  bit            m_boot = 1'b1, m_hold = 1'b0, m_trap = 1'b0, m_mis = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  task automatic cycle();
    if (seq) next_pc = m_pc + 32'd4;
    imem_valid = 1'b0;
    imem_rdata = '0;
    vstale     = 1'b0;
    if (pend && due == t) begin
      imem_valid = 1'b1;
      imem_rdata = word(paddr);
      vstale     = pstale;
      pend       = 1'b0;
    end else if (!pend && imem_req === 1'b1 && !rst) begin
      pend   = 1'b1;
      pstale = 1'b0;
      paddr  = imem_addr;
      due    = t + int'($urandom_range(lat_hi, lat_lo));
    end
    if (rst) begin
      // Only a response landing in the post-reset idle cycle survives a reset.
      if (pend && due != t + 1) pend = 1'b0;
      else if (pend) pstale = 1'b1;
    end else if (flush && !m_trap && pend) begin
      pstale = 1'b1;
    end

    if (rst) begin
      m_pc = 32'h0000_0000; m_inst = 32'h0000_0013; m_cnt = '0;
      m_boot = 1'b1; m_hold = 1'b0; m_trap = 1'b0; m_mis = 1'b0;
    end else if (m_trap) begin
    end else if (flush) begin
      m_pc = flush_addr; m_boot = 1'b0; m_hold = 1'b0;
      if (flush_addr[1:0] != 2'b00) begin m_trap = 1'b1; m_mis = 1'b1; end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_hold) begin
      if (!stall) begin
        m_cnt  = m_cnt + 1'b1;
        m_hold = 1'b0;
        m_pc   = next_pc;
        if (next_pc[1:0] != 2'b00) begin m_trap = 1'b1; m_mis = 1'b1; end
      end
    end else if (imem_valid && !vstale) begin
      m_inst = imem_rdata;
      m_hold = 1'b1;
    end
    t++;

    @(negedge clk);
    check("imem_req",   32'(imem_req),   32'(!m_boot && !m_hold && !m_trap));
    check("imem_addr",  imem_addr,       m_pc);
    check("inst_valid", 32'(inst_valid), 32'(m_hold));
    check("inst",       inst,            m_inst);
    check("pc",         pc,              m_pc);
    check("pc_4",       pc_4,            m_pc + 32'd4);
    check("misaligned", 32'(misaligned), 32'(m_mis));
    check("inst_count", 32'(inst_count), 32'(m_cnt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_hold(input int limit);
    for (int i = 0; i < limit && !m_hold; i++) cycle();
    check("wait_hold", 32'(m_hold), 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_addr = '0;
    next_pc = '0; imem_valid = 1'b0; imem_rdata = '0;
    run(2);
    rst = 1'b0;
    run(10);

    // Branch taken from 0x10 to 0x40.
    for (int i = 0; i < 60 && !(m_hold && m_pc == 32'h10); i++) cycle();
    check("reach_0x10", pc, 32'h10);
    seq = 1'b0; next_pc = 32'h40;
    cycle();
    seq = 1'b1;
    run(6);

    // Stall five cycles in the hold state.
    wait_hold(20);
    stall = 1'b1; run(5);
    stall = 1'b0; run(4);

    // Redirect while a latency-3 request is outstanding.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 40 && !(pend && !pstale && due == t + 2); i++) cycle();
    check("issue_seen", 32'(pend), 32'd1);
    flush = 1'b1; flush_addr = 32'h100;
    cycle();
    flush = 1'b0;
    run(15);
    lat_lo = 1; lat_hi = 1;

    // Address wrap at the top of memory.
    flush = 1'b1; flush_addr = 32'hFFFF_FFFC;
    cycle();
    flush = 1'b0;
    run(12);

    // Misaligned branch target traps; flush is ignored; reset recovers.
    wait_hold(20);
    seq = 1'b0; next_pc = 32'h22;
    cycle();
    run(5);
    flush = 1'b1; flush_addr = 32'h0;
    cycle();
    flush = 1'b0;
    run(3);
    rst = 1'b1; cycle();
    rst = 1'b0; seq = 1'b1;
    run(5);

    // Long unstalled run so the narrow counter wraps.
    run(900);

    // Randomized traffic.
    seq = 1'b0; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      rst   = m_trap ? ($urandom_range(9, 0) == 0) : ($urandom_range(499, 0) == 0);
      stall = ($urandom_range(2, 0) == 0);
      flush = ($urandom_range(11, 0) == 0);
      flush_addr = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(15, 0) == 0) flush_addr = flush_addr | 32'(1 + $urandom_range(2, 0));
      r = $urandom_range(99, 0);
      if (r < 70)      next_pc = m_pc + 32'd4;
      else if (r < 98) next_pc = $urandom() & 32'hFFFF_FFFC;
      else             next_pc = $urandom() | 32'h1;
      cycle();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage feeding the branch-target block.
- Holds the architectural PC and issues one request at a time to instruction memory.
- Presents inst, pc and pc_4 to decode/compare/branch logic.
- On acceptance, loads the selected next address (sequential pc_4 or branch target) back into the PC.
- Handles stall, flush-redirect and misaligned-target trap.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 32, width of fetched-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
next_pc  in  32  next address chosen downstream (branch block output); sampled only on accept
stall  in  1  consumer not ready; holds current instruction
flush  in  1  redirect request (jump/exception); priority over everything except rst
flush_addr  in  32  redirect target
imem_req  out  1  request valid to instruction memory
imem_addr  out  32  request address (= pc)
imem_rdata  in  32  returned instruction word
imem_valid  in  1  one-cycle pulse, response to the outstanding request
inst  out  32  held instruction
inst_valid  out  1  inst/pc/pc_4 valid this cycle
pc  out  32  address of inst
pc_4  out  32  pc + 4, modulo 2^32
misaligned  out  1  sticky trap flag
inst_count  out  CNT_WIDTH  instructions accepted since reset

Behaviour:
- Reset: while rst=1 on a clock edge, the registers take these values:
  - state=S_IDLE, pc=RESET_PC, inst=32'h0000_0013 (NOP).
  - inst_valid=0, imem_req=0, misaligned=0, inst_count=0, drop=0.
- States: S_IDLE, S_FETCH, S_HOLD, S_TRAP.
- S_IDLE: one cycle after reset release, then S_FETCH.
- S_FETCH:
  - Outputs: imem_req=1, imem_addr=pc.
  - At most one outstanding request.
  - Memory latency is ≥1 cycle: the first request is in cycle N; imem_valid arrives no earlier than cycle N+1.
  - On imem_valid with drop=0: inst<=imem_rdata, inst_valid<=1, go to S_HOLD. The instruction is visible the cycle after imem_valid.
  - On imem_valid with drop=1: discard the data, clear drop, stay in S_FETCH and request at the current pc.
- S_HOLD:
  - Outputs: inst_valid=1, imem_req=0.
  - Accept condition: stall=0.
  - On accept: pc<=next_pc, inst_count+=1, inst_valid<=0, go to S_FETCH.
  - While stall=1: all outputs hold.
- Flush (flush=1, any state other than S_TRAP):
  - pc<=flush_addr, inst_valid<=0, go to S_FETCH.
  - If in S_FETCH with imem_valid=0, set drop=1 (the response still in flight is discarded).
  - If imem_valid=1 in the same cycle, the data is discarded and drop stays 0.
  - Flush during S_HOLD does not increment inst_count.
- Alignment trap:
  - Any PC load (next_pc on accept, or flush_addr) with addr[1:0]!=0 sets misaligned<=1 and enters S_TRAP. pc still loads the offending address.
  - S_TRAP: imem_req=0, inst_valid=0, flush ignored. Exit only via rst.
- Arithmetic:
  - pc_4 is combinational, 32-bit wrap: pc=32'hFFFF_FFFC gives pc_4=0.
  - inst_count wraps at 2^CNT_WIDTH.
- imem_valid in S_IDLE/S_HOLD/S_TRAP with drop=0 is ignored.
- Reset mid-request: the state returns to S_IDLE. A late imem_valid arriving in S_IDLE is ignored; S_IDLE's single cycle covers memories with latency 1.

Decomposition:
- Package fetch_pkg:
  - state enum (S_IDLE, S_FETCH, S_HOLD, S_TRAP)
  - NOP constant 32'h0000_0013
  - default RESET_PC
- Sub-module pc_reg: 32-bit register with sync reset to a RESET_PC parameter, load enable and data input.
  - Also outputs pc_4 and a misalign check of its data input.
- FSM, drop flag and counter live in fetch_unit.

Test Plan:
- Reset release, memory latency 1, stall=0, next_pc=pc_4:
  - imem_addr sequence is 0x0, 0x4, 0x8.
  - inst_valid is high every 3rd cycle.
  - inst_count reaches 3 after the third accept.
- Branch taken: in S_HOLD with pc=0x10, drive next_pc=0x40, stall=0 → next imem_addr=0x40 and pc=0x40.
- Stall 5 cycles in S_HOLD with inst=0x00A00093 → inst, pc and inst_valid are stable for all 5 cycles; the count increments once, after release.
- Flush while a request is outstanding:
  - Request to 0x8; flush to 0x100 before imem_valid; the stale word returns 2 cycles later.
  - Required: the stale word is dropped, the next request goes to 0x100, and inst_valid only shows the word from 0x100.
- Misaligned target: accept with next_pc=0x22 → misaligned=1, imem_req=0 forever. A subsequent flush to 0x0 is ignored; rst recovers to pc=RESET_PC.
- Wrap-around: pc=0xFFFF_FFFC → pc_4=0x0; accepting with next_pc=pc_4 fetches 0x0.
